// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-through cache, one-word lines, true LRU,
// req/ack memory port with arbitrary latency and whole-cache flush.
module assoc_cache_ctrl #(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 4,
  parameter int WIDTH    = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [WIDTH/8-1:0] be_i,
  input  logic [WIDTH-1:0]   addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               hit_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [WIDTH/8-1:0] mem_be_o,
  output logic [WIDTH-1:0]   mem_addr_o,
  output logic [WIDTH-1:0]   mem_wdata_o,
  input  logic [WIDTH-1:0]   mem_rdata_i,
  input  logic               mem_ack_i
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int BE_W  = WIDTH / 8;
  localparam int AGE_W = $clog2(WAYS);
  localparam int TAG_W = WIDTH - SET_BITS - 2;

  typedef logic [AGE_W-1:0] age_t;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q  [SETS][WAYS];
  logic [WIDTH-1:0]   data_d  [SETS][WAYS];
  logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
  logic [TAG_W-1:0]   tag_d   [SETS][WAYS];
  logic               valid_q [SETS][WAYS];
  logic               valid_d [SETS][WAYS];
  age_t               age_q   [SETS][WAYS];
  age_t               age_d   [SETS][WAYS];

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    tag;
  logic [WIDTH-1:0]    line_addr;
  logic                hit;
  age_t                hit_way;
  age_t                vic_way;
  logic                touch_en;
  age_t                touch_way;
  age_t                touch_age;
  logic                unused_addr;

  assign set_idx     = addr_i[SET_BITS+1:2];
  assign tag         = addr_i[WIDTH-1:SET_BITS+2];
  assign line_addr   = {addr_i[WIDTH-1:2], 2'b00};
  assign unused_addr = ^addr_i[1:0];
  assign hit_o       = hit;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = age_t'(w);
      end
      if (age_q[set_idx][w] == '0) vic_way = age_t'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_idx][w]) vic_way = age_t'(w);
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    age_d       = age_q;
    ready_o     = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    touch_en    = 1'b0;
    touch_way   = '0;
    touch_age   = '0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              valid_d[s][w] = 1'b0;
        end else if (req_i) begin
          if (we_i) begin
            state_d = WR_WAIT;
          end else if (hit) begin
            ready_o   = 1'b1;
            rdata_o   = data_q[set_idx][hit_way];
            touch_en  = 1'b1;
            touch_way = hit_way;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        mem_req_o  = 1'b1;
        mem_addr_o = line_addr;
        if (mem_ack_i) begin
          ready_o   = 1'b1;
          rdata_o   = mem_rdata_i;
          data_d[set_idx][vic_way]  = mem_rdata_i;
          tag_d[set_idx][vic_way]   = tag;
          valid_d[set_idx][vic_way] = 1'b1;
          touch_en  = 1'b1;
          touch_way = vic_way;
          state_d   = IDLE;
        end
      end
      WR_WAIT: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_be_o    = be_i;
        mem_addr_o  = line_addr;
        mem_wdata_o = wdata_i;
        if (mem_ack_i) begin
          ready_o = 1'b1;
          state_d = IDLE;
          if (hit) begin
            for (int b = 0; b < BE_W; b++)
              if (be_i[b])
                data_d[set_idx][hit_way][8*b +: 8] = wdata_i[8*b +: 8];
            touch_en  = 1'b1;
            touch_way = hit_way;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Touched way becomes MRU; younger ways slide down to keep a permutation.
    if (touch_en) begin
      touch_age = age_q[set_idx][touch_way];
      for (int w = 0; w < WAYS; w++) begin
        if (age_t'(w) == touch_way)
          age_d[set_idx][w] = age_t'(WAYS - 1);
        else if (age_q[set_idx][w] > touch_age)
          age_d[set_idx][w] = age_q[set_idx][w] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          data_q[s][w]  <= '0;
          tag_q[s][w]   <= '0;
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= age_t'(w);
        end
      end
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

endmodule
